sram_stream_reader: RTL

Read-side client for the dual-port SRAM wrapper (1-cycle read latency, 128-bit words, 12-bit address). On a start pulse it walks a contiguous address range through the wrapper's read port (re/radr/q) and presents the words as a valid/ready stream. A 2-entry skid FIFO absorbs the read latency under consumer backpressure, so no read data is ever dropped. It sits between a wrapper instance and a downstream datapath consumer, such as the conv engine operand feed.

---
 rtl/sram_stream_reader_pkg.sv | 7 +
 rtl/stream_skid_fifo.sv | 36 +++
 rtl/sram_stream_reader.sv | 68 ++++++
 3 files changed

// File: rtl/sram_stream_reader_pkg.sv
// sram_stream_reader_pkg: shared SRAM geometry and reader state encoding.
package sram_stream_reader_pkg;
  localparam int DATA_WIDTH = 128;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH = 4096;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry synchronous FIFO catching SRAM read data under backpressure.
module stream_skid_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         valid_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   count_q;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign valid_o = count_q != 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end
endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: walks an SRAM address range and streams the words out as valid/ready beats.
module sram_stream_reader #(
  parameter int DATA_WIDTH = sram_stream_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_stream_reader_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_re,
  output logic [ADDR_WIDTH-1:0] sram_radr,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  import sram_stream_reader_pkg::*;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q, issued_q;
  logic                  inflight_q, pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  stream_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (sram_q),
    .head_o  (out_data),
    .count_o (fifo_count),
    .valid_o (out_valid)
  );
  // occupancy after this edge, counting the word still in flight from the SRAM
  assign pop       = out_valid && out_ready;
  assign occ       = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign sram_re   = state_q == READ && issued_q < num_q && occ < 3'(FIFO_DEPTH);
  assign sram_radr = base_q + issued_q[ADDR_WIDTH-1:0];
  assign busy      = state_q == READ || state_q == DRAIN;
  assign done      = state_q == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= sram_re;
      if (sram_re) issued_q <= issued_q + 1'b1;
      case (state_q)
        IDLE: if (start) begin
          base_q   <= base_addr;
          num_q    <= num_words;
          issued_q <= '0;
          state_q  <= num_words == '0 ? DONE : READ;
        end
        READ:    if (issued_q == num_q) state_q <= DRAIN;
        DRAIN:   if (occ == 3'd0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
